uart_tx: RTL and testbench

- UART transmit serializer; sits directly downstream of the baud tick generator and consumes its one-cycle `tick` pulse (one pulse per bit period, 115200 bps at 50 MHz).
- Accepts parallel bytes over a valid/ready handshake and emits asynchronous serial frames on `tx`: start bit, data LSB-first, optional parity, stop bit(s).
- Drives the top-level UART TX pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx.sv | 144 ++++++++++++++
 tb/tb_uart_tx.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, line levels and default
// frame shape, common to uart_tx and the future uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_STOP_BITS = 1;

endpackage

// File: rtl/uart_tx.sv
// UART transmit serializer driven by an external baud tick: start bit, data
// LSB-first, optional parity (UART_TX_PARITY_EN), then STOP_BITS stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int STOP_BITS  = DEFAULT_STOP_BITS,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int               CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic             PAR_SENSE = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    tx_state_t            state;
    tx_state_t            state_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic                 tx_next;
    logic                 accept;

`ifdef UART_TX_PARITY_EN
    logic par;
    logic par_next;
`endif

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = tx_valid && tx_ready;

    // tx_next is the level for the current state; registering it delays the
    // line by exactly one clk behind every state change.
    always_comb begin
        state_next = state;
        shift_next = shift;
        cnt_next   = cnt;
        tx_next    = LINE_IDLE;
`ifdef UART_TX_PARITY_EN
        par_next   = par;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SYNC;
                    shift_next = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_next   = (^tx_data) ^ PAR_SENSE;
`endif
                end
            end
            SYNC: begin
                if (tick) begin
                    state_next = START;
                end
            end
            START: begin
                tx_next = START_LVL;
                if (tick) begin
                    state_next = DATA;
                    cnt_next   = '0;
                end
            end
            DATA: begin
                tx_next = shift[0];
                if (tick) begin
                    shift_next = shift >> 1;
                    if (cnt == DATA_LAST) begin
                        cnt_next   = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_next = par;
                if (tick) begin
                    state_next = STOP;
                end
            end
`else
            // Never entered without parity; the line simply stays idle-high.
            PARITY: begin
                tx_next    = LINE_IDLE | PAR_SENSE;
                state_next = STOP;
            end
`endif
            STOP: begin
                tx_next = LINE_IDLE;
                if (tick) begin
                    if (cnt == STOP_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Asynchronous reset drops any frame in flight and forces the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shift <= '0;
            cnt   <= '0;
            tx    <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            shift <= shift_next;
            cnt   <= cnt_next;
            tx    <= tx_next;
`ifdef UART_TX_PARITY_EN
            par   <= par_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a driver pushes accepted bytes, monitors
// rebuild the expected serial frame and check every clk of every bit period.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int DB     = 8;
    localparam int PAR_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b0;
    logic [7:0] data0 = '0;
    logic [7:0] data1 = '0;
    logic       valid0 = 1'b0;
    logic       valid1 = 1'b0;
    logic       rdy0, rdy1, tx0, tx1, busy0, busy1;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         acc_q0[$];
    int         acc_q1[$];
    int         starts0[$];
    int         ends0[$];
    bit         active0 = 1'b0;
    bit         active1 = 1'b0;

    uart_tx #(.DATA_BITS(DB), .STOP_BITS(1), .PARITY_ODD(PAR_ODD)) dut0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .tx_data(data0), .tx_valid(valid0),
        .tx_ready(rdy0), .tx(tx0), .busy(busy0)
    );

    uart_tx #(.DATA_BITS(DB), .STOP_BITS(2), .PARITY_ODD(PAR_ODD)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .tx_data(data1), .tx_valid(valid1),
        .tx_ready(rdy1), .tx(tx1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Baud tick: one clk high out of every four.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            tick = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endfunction

    function automatic logic txv(input int idx);
        return (idx == 0) ? tx0 : tx1;
    endfunction
    function automatic logic busyv(input int idx);
        return (idx == 0) ? busy0 : busy1;
    endfunction
    function automatic logic rdyv(input int idx);
        return (idx == 0) ? rdy0 : rdy1;
    endfunction

    function automatic int frame_len(input int stops);
        return 1 + DB + PBITS + stops;
    endfunction

    // Line level for each bit period of a frame, index 0 = start bit.
    function automatic logic [15:0] frame_bits(input logic [7:0] b);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DB; i++) f[1 + i] = b[i];
        if (PBITS == 1) f[1 + DB] = (^b) ^ PAR_ODD[0];
        return f;
    endfunction

    task automatic monitor(input int idx, input int stops);
        logic [7:0]  b;
        logic [15:0] f;
        int          n, start, acc, k, ph, w;
        bit          aborted, last;
        forever begin
            @(negedge clk);
            if (rst_n && txv(idx) == 1'b0) begin
                if ((idx == 0 && exp_q0.size() == 0) || (idx == 1 && exp_q1.size() == 0)) begin
                    check($sformatf("d%0d_unexpected_frame", idx), txv(idx), 1);
                    w = 0;
                    while (txv(idx) == 1'b0 && w < 100) begin
                        @(negedge clk);
                        w++;
                    end
                end else begin
                    if (idx == 0) begin
                        b = exp_q0.pop_front(); acc = acc_q0.pop_front(); active0 = 1'b1;
                    end else begin
                        b = exp_q1.pop_front(); acc = acc_q1.pop_front(); active1 = 1'b1;
                    end
                    start = cyc;
                    if (idx == 0) starts0.push_back(start);
                    check($sformatf("d%0d_latency_in_2_to_5", idx),
                          ((start - acc) >= 2 && (start - acc) <= 5) ? 1 : 0, 1);
                    f = frame_bits(b);
                    n = frame_len(stops);
                    aborted = 1'b0;
                    for (int t = 0; t < 4 * n && !aborted; t++) begin
                        if (t > 0) @(negedge clk);
                        if (!rst_n) begin
                            aborted = 1'b1;
                        end else begin
                            k = t / 4;
                            ph = t % 4;
                            last = (k == n - 1) && (ph == 3);
                            check($sformatf("d%0d_byte%02h_bit%0d_ph%0d", idx, b, k, ph), txv(idx), f[k]);
                            check($sformatf("d%0d_busy_bit%0d_ph%0d", idx, k, ph), busyv(idx), last ? 0 : 1);
                            check($sformatf("d%0d_ready_bit%0d_ph%0d", idx, k, ph), rdyv(idx), last ? 1 : 0);
                        end
                    end
                    if (!aborted && idx == 0) ends0.push_back(start + 4 * n);
                    if (idx == 0) active0 = 1'b0; else active1 = 1'b0;
                end
            end
        end
    endtask

    initial monitor(0, 1);
    initial monitor(1, 2);

    task automatic send(input int idx, input logic [7:0] b, input bit hold, output int acc);
        bit r;
        int n;
        n = 0;
        acc = -1;
        if (idx == 0) begin data0 = b; valid0 = 1'b1; end
        else begin data1 = b; valid1 = 1'b1; end
        while (acc < 0 && n < 2000) begin
            r = rdyv(idx);
            @(posedge clk);
            #1;
            if (r) begin
                acc = cyc;
                if (idx == 0) begin exp_q0.push_back(b); acc_q0.push_back(cyc); end
                else begin exp_q1.push_back(b); acc_q1.push_back(cyc); end
            end
            n++;
        end
        check($sformatf("d%0d_accept_%02h", idx, b), (acc >= 0) ? 1 : 0, 1);
        if (!hold) begin
            if (idx == 0) valid0 = 1'b0; else valid1 = 1'b0;
        end
    endtask

    task automatic drain(input int idx);
        int n;
        n = 0;
        while (n < 4000 && ((idx == 0) ? (exp_q0.size() != 0 || active0)
                                       : (exp_q1.size() != 0 || active1))) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("d%0d_drain", idx), (n < 4000) ? 1 : 0, 1);
    endtask

    initial begin
        int a, a2, n, s2, e1;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx0", tx0, 1);
        check("reset_ready0", rdy0, 1);
        check("reset_busy0", busy0, 0);
        check("reset_tx1", tx1, 1);
        check("reset_ready1", rdy1, 1);
        check("reset_busy1", busy1, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_ticks_no_effect_tx", tx0, 1);
        check("idle_ticks_no_effect_busy", busy0, 0);
        #1;

        // Single 0x55 frame, parity per build.
        send(0, 8'h55, 1'b0, a);
        drain(0);

        // Back-to-back with valid held high.
        @(negedge clk); #1;
        send(0, 8'h55, 1'b1, a);
        send(0, 8'h0F, 1'b0, a2);
        drain(0);
        s2 = starts0[starts0.size() - 1];
        e1 = ends0[ends0.size() - 2];
        check("b2b_accept_first_idle_cycle", a2, e1);
        check("b2b_line_gap_clks", s2 - e1, 4);

        // Accept in the same cycle as a tick.
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(tick && rdy0) && n < 100);
        send(0, 8'hC3, 1'b0, a);
        drain(0);
        check("coincident_tick_latency", starts0[starts0.size() - 1] - a, 5);

        // Reset in the middle of the data bits.
        @(negedge clk); #1;
        send(0, 8'hA5, 1'b0, a);
        n = 0;
        while (!active0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (17) @(posedge clk);
        #1;
        check("pre_reset_tx_low_on_d3", tx0, 0);
        rst_n = 1'b0;
        #1;
        check("async_reset_tx", tx0, 1);
        check("async_reset_ready", rdy0, 1);
        check("async_reset_busy", busy0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("held_reset_tx", tx0, 1);
        check("held_reset_busy", busy0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        send(0, 8'h3C, 1'b0, a);
        drain(0);

        // Parity patterns.
        send(0, 8'h07, 1'b0, a);
        send(0, 8'h03, 1'b0, a);
        drain(0);

        // Two stop bits.
        @(negedge clk); #1;
        send(1, 8'hFF, 1'b0, a);
        drain(1);

        // Randomized traffic on both instances.
        for (int i = 0; i < 14; i++) begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
            #1;
            send(0, 8'($urandom), 1'b0, a);
        end
        drain(0);
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
            #1;
            send(1, 8'($urandom), 1'b0, a);
        end
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
